// File: rtl/amns_res_collector.sv
// amns_res_collector: collects the N result words of the last PE, removes the
// reduced low digit with an arithmetic shift, buffers the N signed coefficients
// and drains them in index order over a valid/ready stream.
// Two sticky error flags are kept:
//  - the low digit of a captured word was not zero;
//  - result data arrived while the block was not collecting.
module amns_res_collector #(
  parameter int N = 5,
  parameter int RES_W = 48,
  parameter int SHIFT = 17,
  localparam int COEF_W = RES_W - SHIFT,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              res_valid_i,
  input  logic [RES_W-1:0]  res_i,
  output logic              busy_o,
  output logic              coef_valid_o,
  input  logic              coef_ready_i,
  output logic [COEF_W-1:0] coef_o,
  output logic [IDX_W-1:0]  coef_idx_o,
  output logic              last_o,
  output logic              done_o,
  output logic              err_nonzero_low_o,
  output logic              err_protocol_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_wr;
  logic [IDX_W-1:0]    r_rd;
  logic [COEF_W-1:0]   r_buf [N];
  logic                r_busy;
  logic                r_valid;
  logic [COEF_W-1:0]   r_coef;
  logic [IDX_W-1:0]    r_idx;
  logic                r_last;
  logic                r_done;
  logic                r_err_nz;
  logic                r_err_proto;

  logic                w_cap;
  logic                w_low_nz;
  logic [IDX_W-1:0]    w_rd_next;

  // A word is captured only while collecting; anything else is misuse.
  assign w_cap     = (r_state == ST_COLLECT) && res_valid_i;
  assign w_low_nz  = |res_i[SHIFT-1:0];
  assign w_rd_next = r_rd + IDX_W'(1);

  // Coefficient buffer: upper bits of each captured word (arithmetic shift by
  // truncation, sign bit preserved); contents need no reset.
  always_ff @(posedge clock_i) begin
    if (w_cap) begin
      r_buf[r_wr] <= res_i[RES_W-1:SHIFT];
    end
  end

  // Control FSM with registered stream, status and error outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_wr        <= '0;
      r_rd        <= '0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_coef      <= '0;
      r_idx       <= '0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
      r_err_nz    <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state     <= ST_COLLECT;
            r_wr        <= '0;
            r_busy      <= 1'b1;
            r_err_nz    <= 1'b0;
            // A word arriving together with start is still misuse.
            r_err_proto <= res_valid_i;
          end else if (res_valid_i) begin
            r_err_proto <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (res_valid_i) begin
            if (w_low_nz) begin
              r_err_nz <= 1'b1;
            end
            if (r_wr == LAST_IDX) begin
              // Index 0 was written on an earlier edge since N >= 2.
              r_state <= ST_DRAIN;
              r_rd    <= '0;
              r_valid <= 1'b1;
              r_coef  <= r_buf[0];
              r_idx   <= '0;
              r_last  <= 1'b0;
            end else begin
              r_wr <= r_wr + IDX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (res_valid_i) begin
            r_err_proto <= 1'b1;
          end
          if (coef_ready_i) begin
            if (r_last) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
              r_coef  <= '0;
              r_idx   <= '0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_rd   <= w_rd_next;
              r_coef <= r_buf[w_rd_next];
              r_idx  <= w_rd_next;
              r_last <= (w_rd_next == LAST_IDX);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o            = r_busy;
  assign coef_valid_o      = r_valid;
  assign coef_o            = r_coef;
  assign coef_idx_o        = r_idx;
  assign last_o            = r_last;
  assign done_o            = r_done;
  assign err_nonzero_low_o = r_err_nz;
  assign err_protocol_o    = r_err_proto;

endmodule

// File: tb/tb_amns_res_collector.sv
// Self-checking bench for amns_res_collector: directed and random operations
// compared against a queue-based reference model of the collector.
module tb_amns_res_collector;

  localparam int N = 5;
  localparam int RES_W = 48;
  localparam int SHIFT = 17;
  localparam int COEF_W = RES_W - SHIFT;
  localparam int IDX_W = $clog2(N);

  typedef logic [RES_W-1:0] word_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              rv;
  logic [RES_W-1:0]  res;
  logic              ready;
  logic              busy;
  logic              cvalid;
  logic [COEF_W-1:0] coef;
  logic [IDX_W-1:0]  cidx;
  logic              last;
  logic              done;
  logic              err_nz;
  logic              err_proto;

  amns_res_collector #(.N(N), .RES_W(RES_W), .SHIFT(SHIFT)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .res_valid_i(rv),
    .res_i(res), .busy_o(busy), .coef_valid_o(cvalid), .coef_ready_i(ready),
    .coef_o(coef), .coef_idx_o(cidx), .last_o(last), .done_o(done),
    .err_nonzero_low_o(err_nz), .err_protocol_o(err_proto)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit                m_nz;
  bit                m_proto;
  logic [COEF_W-1:0] q[$];

  // Options for run_op
  int opt_gap;
  int opt_rmode;
  bit opt_sv_start;
  bit opt_busy_start;
  bit opt_drain_valid;
  bit opt_chain;
  bit opt_reset3;

  function automatic logic [COEF_W-1:0] ref_coef(input word_t w);
    logic signed [RES_W-1:0] s;
    s = w;
    s = s >>> SHIFT;
    return s[COEF_W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [RES_W-1:0] obs, input logic [RES_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, cvalid, 0);
    chk({tag, "_coef"}, coef, 0);
    chk({tag, "_idx"}, cidx, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_errnz"}, err_nz, 0);
    chk({tag, "_errproto"}, err_proto, 0);
  endtask

  task automatic run_op(input word_t w[N]);
    int cyc;
    int stall;
    int eidx;
    int gaps;
    bit rdy;
    // accepted start (optionally with a stray word that must be discarded)
    start = 1'b1;
    rv = opt_sv_start;
    res = 48'h0000_ABCD_0001;
    tick;
    start = 1'b0;
    rv = 1'b0;
    m_nz = 1'b0;
    m_proto = opt_sv_start;
    q.delete();
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_errnz", err_nz, 0);
    chk("start_errproto", err_proto, m_proto);
    for (int i = 0; i < N; i++) begin
      gaps = $urandom_range(opt_gap, 0);
      repeat (gaps) tick;
      if (opt_busy_start && i == 2) begin
        start = 1'b1;
        tick;
        start = 1'b0;
      end
      rv = 1'b1;
      res = w[i];
      tick;
      rv = 1'b0;
      q.push_back(ref_coef(w[i]));
      if (w[i][SHIFT-1:0] != 17'd0) m_nz = 1'b1;
      if (i < N - 1) chk("collect_novalid", cvalid, 0);
    end
    chk("collect_errnz", err_nz, m_nz);
    cyc = 0;
    stall = 0;
    eidx = 0;
    while (q.size() > 0 && cyc < 200) begin
      chk("drain_valid", cvalid, 1);
      chk("drain_coef", coef, q[0]);
      chk("drain_idx", cidx, eidx);
      chk("drain_last", last, (eidx == N - 1));
      chk("drain_busy", busy, 1);
      chk("drain_done", done, 0);
      chk("drain_errnz", err_nz, m_nz);
      chk("drain_errproto", err_proto, m_proto);
      if (opt_reset3 && eidx == 3) begin
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        #1 rst = 1'b0;
        q.delete();
        m_nz = 1'b0;
        m_proto = 1'b0;
        return;
      end
      case (opt_rmode)
        0: rdy = 1'b1;
        1: begin
          rdy = !(eidx == 2 && stall < 3);
          if (!rdy) stall++;
        end
        default: rdy = ($urandom_range(1, 0) == 1);
      endcase
      ready = rdy;
      if (opt_drain_valid && cyc == 0) begin
        rv = 1'b1;
        res = {$urandom, 16'h0};
        m_proto = 1'b1;
      end
      if (opt_drain_valid && cyc == 1) start = 1'b1;
      tick;
      rv = 1'b0;
      start = 1'b0;
      ready = 1'b1;
      cyc++;
      if (rdy) begin
        void'(q.pop_front());
        eidx++;
      end
    end
    chk("drain_timeout", q.size(), 0);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_valid", cvalid, 0);
    chk("end_last", last, 0);
    chk("end_errnz", err_nz, m_nz);
    chk("end_errproto", err_proto, m_proto);
    if (opt_rmode == 0 && !opt_drain_valid) chk("drain_cycles", cyc, N);
    if (opt_rmode == 1) chk("stall_cycles", cyc, N + 3);
    if (!opt_chain) begin
      tick;
      chk("done_pulse", done, 0);
    end
  endtask

  word_t w[N];
  logic [COEF_W-1:0] rc;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rv = 1'b0;
    res = '0;
    ready = 1'b1;
    opt_gap = 0; opt_rmode = 0; opt_sv_start = 0; opt_busy_start = 0;
    opt_drain_valid = 0; opt_chain = 0; opt_reset3 = 0;
    tick;
    tick;
    chk_all_zero("reset");
    rst = 1'b0;
    tick;
    chk_all_zero("post_reset");

    // basic pass
    for (int k = 0; k < N; k++) w[k] = word_t'(k + 1) << SHIFT;
    run_op(w);

    // res_valid in IDLE
    rv = 1'b1;
    res = 48'h0000_0005_0000;
    tick;
    rv = 1'b0;
    chk("idle_valid_proto", err_proto, 1);
    chk("idle_valid_busy", busy, 0);
    chk("idle_valid_cvalid", cvalid, 0);

    // sign handling, busy-time start, gaps, backpressure at idx 2
    w[0] = 48'hFFFF_FFFE_0000;
    w[1] = 48'h7FFF_FFFE_0000;
    w[2] = 48'h8000_0000_0000;
    w[3] = 48'h0000_0006_0000;
    w[4] = 48'hFFFF_FFF0_0000;
    opt_gap = 2; opt_rmode = 1; opt_busy_start = 1; opt_chain = 1;
    run_op(w);

    // exactness, start in done cycle, start with stray word, misuse in drain
    for (int k = 0; k < N; k++) w[k] = word_t'(k + 1) << SHIFT;
    w[2] = (word_t'(7) << SHIFT) | 48'd1;
    opt_gap = 0; opt_rmode = 0; opt_busy_start = 0; opt_chain = 0;
    opt_sv_start = 1; opt_drain_valid = 1;
    run_op(w);

    // async reset mid-drain
    opt_sv_start = 0; opt_drain_valid = 0; opt_reset3 = 1;
    for (int k = 0; k < N; k++) w[k] = word_t'(k + 9) << SHIFT;
    run_op(w);
    opt_reset3 = 0;
    tick;
    chk_all_zero("after_reset");

    // random operations
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < N; k++) begin
        rc = COEF_W'($urandom);
        w[k] = {rc, 17'd0};
        if ($urandom_range(7, 0) == 0) w[k][SHIFT-1:0] = 17'($urandom_range(131071, 1));
      end
      opt_gap = 3; opt_rmode = 2;
      run_op(w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
